// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue
//   Write-side initiator for the register file's single write port.
//   It accepts writebacks from the MEM and ALU producers through valid/ready,
//   holds them in a small in-order FIFO, and drains at most one entry per cycle
//   into the register file.
//
//   Optional feature macro: WBQ_FWD_EN
//     defined   -> still-queued values are forwarded to the ID-stage sources
//                  src1/src2. The youngest matching entry wins.
//     undefined -> no compare logic is built. fwd*_hit and fwd*_val are tied to 0.
//
//   Handshake: a producer transfers on any rising edge where valid && ready.
//   ready never depends on this cycle's pop, so there is no pop->ready path.
//   A transfer with dest == 0 completes the handshake but is not enqueued.

`ifndef REG_FILE_ADDR_LEN
`define REG_FILE_ADDR_LEN 5
`endif
`ifndef REG_FILE_SIZE
`define REG_FILE_SIZE 32
`endif

module reg_writeback_queue #(
  parameter int ADDR_W = `REG_FILE_ADDR_LEN,
  parameter int DATA_W = `REG_FILE_SIZE,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_valid,
  input  logic [ADDR_W-1:0]         mem_dest,
  input  logic [DATA_W-1:0]         mem_val,
  output logic                      mem_ready,
  input  logic                      alu_valid,
  input  logic [ADDR_W-1:0]         alu_dest,
  input  logic [DATA_W-1:0]         alu_val,
  output logic                      alu_ready,
  input  logic                      wb_stall,
  output logic                      writeEn,
  output logic [ADDR_W-1:0]         dest,
  output logic [DATA_W-1:0]         writeVal,
  input  logic [ADDR_W-1:0]         src1,
  input  logic [ADDR_W-1:0]         src2,
  output logic                      fwd1_hit,
  output logic [DATA_W-1:0]         fwd1_val,
  output logic                      fwd2_hit,
  output logic [DATA_W-1:0]         fwd2_val,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] dest_q [DEPTH];
  logic [DATA_W-1:0] val_q  [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic             mem_push;
  logic             alu_push;
  logic             pop;
  logic [PTR_W-1:0] alu_slot;

  // Producer readiness. MEM is older, so it claims a slot first.
  // ALU then gets a slot only if one is left after a valid MEM request.
  always_comb begin
    mem_ready = 1'b0;
    alu_ready = 1'b0;
    if (!rst) begin
      mem_ready = (int'(count_q) < DEPTH);
      alu_ready = ((int'(count_q) + int'(mem_valid)) < DEPTH);
    end
  end

  // Head drive and pop. The register file always accepts the write.
  always_comb begin
    writeEn  = 1'b0;
    dest     = '0;
    writeVal = '0;
    if (!rst && (count_q != '0) && !wb_stall) begin
      writeEn  = 1'b1;
      dest     = dest_q[rd_ptr_q];
      writeVal = val_q[rd_ptr_q];
    end
  end

  assign pop = writeEn;

  // Enqueue decisions. Register 0 writes are handshaken, then dropped.
  // ALU lands right behind MEM when both are enqueued this cycle.
  always_comb begin
    mem_push = mem_valid && mem_ready && (mem_dest != '0);
    alu_push = alu_valid && alu_ready && (alu_dest != '0);
    alu_slot = wr_ptr_q + PTR_W'(mem_push);
  end

  // Next-state pointers and occupancy. The pointers wrap naturally at DEPTH.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(mem_push) + PTR_W'(alu_push);
    count_d  = count_q + CNT_W'(mem_push) + CNT_W'(alu_push) - CNT_W'(pop);
  end

  // Pointer/occupancy registers. Reset discards every queued entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage. The payload needs no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (mem_push) begin
        dest_q[wr_ptr_q] <= mem_dest;
        val_q[wr_ptr_q]  <= mem_val;
      end
      if (alu_push) begin
        dest_q[alu_slot] <= alu_dest;
        val_q[alu_slot]  <= alu_val;
      end
    end
  end

  assign count = count_q;
  assign full  = !rst && (int'(count_q) == DEPTH);
  assign empty = rst || (count_q == '0);

`ifdef WBQ_FWD_EN
  // Forwarding lookup. Walk from head to tail so the youngest match overrides.
  // The entry being popped is still queued this cycle. Same-cycle pushes are not visible.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd1_hit = 1'b0;
    fwd1_val = '0;
    fwd2_hit = 1'b0;
    fwd2_val = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if (!rst && (CNT_W'(i) < count_q)) begin
        if ((src1 != '0) && (dest_q[idx] == src1)) begin
          fwd1_hit = 1'b1;
          fwd1_val = val_q[idx];
        end
        if ((src2 != '0) && (dest_q[idx] == src2)) begin
          fwd2_hit = 1'b1;
          fwd2_val = val_q[idx];
        end
      end
    end
  end
`else
  // Forwarding disabled: the lookup outputs are constant and the sources are ignored.
  logic unused_src;
  assign unused_src = ^{src1, src2};
  assign fwd1_hit   = 1'b0;
  assign fwd1_val   = '0;
  assign fwd2_hit   = 1'b0;
  assign fwd2_val   = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb_reg_writeback_queue
//   Directed bench for reg_writeback_queue with hand-computed expectations.
//   Inputs change 1 time unit after a rising edge. Outputs are checked 1 time
//   unit after that, well clear of the next edge.
//   Forwarding expectations follow WBQ_FWD_EN.

module tb_reg_writeback_queue;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_dest;
  logic [DATA_W-1:0] mem_val;
  logic              mem_ready;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_dest;
  logic [DATA_W-1:0] alu_val;
  logic              alu_ready;
  logic              wb_stall;
  logic              writeEn;
  logic [ADDR_W-1:0] dest;
  logic [DATA_W-1:0] writeVal;
  logic [ADDR_W-1:0] src1;
  logic [ADDR_W-1:0] src2;
  logic              fwd1_hit;
  logic [DATA_W-1:0] fwd1_val;
  logic              fwd2_hit;
  logic [DATA_W-1:0] fwd2_val;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected register-file writes, packed as {dest, value}.
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  reg_writeback_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_val(mem_val), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_val(alu_val), .alu_ready(alu_ready),
    .wb_stall(wb_stall),
    .writeEn(writeEn), .dest(dest), .writeVal(writeVal),
    .src1(src1), .src2(src2),
    .fwd1_hit(fwd1_hit), .fwd1_val(fwd1_val), .fwd2_hit(fwd2_hit), .fwd2_val(fwd2_val),
    .count(count), .full(full), .empty(empty)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid = 1'b0; mem_dest = '0; mem_val = '0;
    alu_valid = 1'b0; alu_dest = '0; alu_val = '0;
    src1 = '0; src2 = '0;
  endtask

  task automatic drive_mem(input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] v);
    mem_valid = 1'b1; mem_dest = d; mem_val = v;
  endtask

  task automatic drive_alu(input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] v);
    alu_valid = 1'b1; alu_dest = d; alu_val = v;
  endtask

  // Check that the current head write matches the oldest expected entry, then consume it.
  task automatic expect_write(input string tag);
    logic [ADDR_W+DATA_W-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_nonempty"}, 64'(0), 64'(1));
    end else begin
      e = exp_q.pop_front();
      check({tag, "_we"},   64'(writeEn),  64'(1));
      check({tag, "_dest"}, 64'(dest),     64'(e[ADDR_W+DATA_W-1:DATA_W]));
      check({tag, "_val"},  64'(writeVal), 64'(e[DATA_W-1:0]));
    end
  endtask

  initial begin
    logic exp_fwd;
`ifdef WBQ_FWD_EN
    exp_fwd = 1'b1;
`else
    exp_fwd = 1'b0;
`endif
    rst = 1'b1;
    wb_stall = 1'b0;
    idle_inputs();

    // 1 Reset: hold reset for two cycles with MEM valid.
    drive_mem(5'd3, 32'd5);
    tick();
    tick();
    settle();
    check("rst_we",        64'(writeEn),   64'(0));
    check("rst_count",     64'(count),     64'(0));
    check("rst_mem_ready", 64'(mem_ready), 64'(0));
    check("rst_alu_ready", 64'(alu_ready), 64'(0));
    check("rst_dest",      64'(dest),      64'(0));
    check("rst_full",      64'(full),      64'(0));
    check("rst_empty",     64'(empty),     64'(1));
    rst = 1'b0;
    idle_inputs();
    settle();
    check("post_rst_empty",     64'(empty),     64'(1));
    check("post_rst_mem_ready", 64'(mem_ready), 64'(1));
    tick();
    check("post_rst_count", 64'(count), 64'(0));

    // 2 Single MEM writeback.
    drive_mem(5'd1, 32'd2);
    settle();
    check("single_ready",  64'(mem_ready), 64'(1));
    check("single_we_pre", 64'(writeEn),   64'(0));
    tick();
    idle_inputs();
    settle();
    check("single_count", 64'(count), 64'(1));
    exp_q.push_back({5'd1, 32'd2});
    expect_write("single");
    tick();
    settle();
    check("single_empty", 64'(empty),   64'(1));
    check("single_we_end", 64'(writeEn), 64'(0));

    // 3 Dual push in one cycle. MEM is older than ALU.
    drive_mem(5'd2, 32'd8);
    drive_alu(5'd2, 32'd9);
    settle();
    check("dual_mem_ready", 64'(mem_ready), 64'(1));
    check("dual_alu_ready", 64'(alu_ready), 64'(1));
    tick();
    idle_inputs();
    src1 = 5'd2;
    src2 = 5'd5;
    settle();
    check("dual_count", 64'(count), 64'(2));
    exp_q.push_back({5'd2, 32'd8});
    exp_q.push_back({5'd2, 32'd9});
    expect_write("dual_w0");
    check("dual_fwd1_hit",  64'(fwd1_hit), 64'(exp_fwd));
    check("dual_fwd1_val",  64'(fwd1_val), exp_fwd ? 64'd9 : 64'd0);
    check("dual_fwd2_miss", 64'(fwd2_hit), 64'(0));
    tick();
    settle();
    expect_write("dual_w1");
    tick();
    src1 = '0;
    src2 = '0;
    settle();
    check("dual_empty", 64'(empty), 64'(1));

    // 4 Fill under stall, hold a fifth entry, then drain in order.
    wb_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive_alu(5'(i), 32'(16 + i));
      settle();
      check("fill_alu_ready", 64'(alu_ready), 64'(1));
      exp_q.push_back({5'(i), 32'(16 + i)});
      tick();
    end
    drive_alu(5'd5, 32'd21);
    settle();
    check("fill_full",      64'(full),      64'(1));
    check("fill_count",     64'(count),     64'(4));
    check("fill_alu_ready", 64'(alu_ready), 64'(0));
    check("fill_mem_ready", 64'(mem_ready), 64'(0));
    check("fill_we_stall",  64'(writeEn),   64'(0));
    tick();
    settle();
    check("fill_held_count", 64'(count), 64'(4));
    wb_stall = 1'b0;
    settle();
    check("drain1_alu_ready", 64'(alu_ready), 64'(0));
    expect_write("drain1");
    tick();
    settle();
    check("drain2_alu_ready", 64'(alu_ready), 64'(1));
    exp_q.push_back({5'd5, 32'd21});
    expect_write("drain2");
    tick();
    idle_inputs();
    settle();
    check("drain3_count", 64'(count), 64'(3));
    for (int i = 3; i <= 5; i++) begin
      expect_write("drain_tail");
      tick();
    end
    settle();
    check("drain_empty",   64'(empty),        64'(1));
    check("drain_q_empty", 64'(exp_q.size()), 64'(0));

    // 5 Arbitration with one free slot: MEM wins.
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_mem(5'(6 + i), 32'(60 + 10 * i));
      exp_q.push_back({5'(6 + i), 32'(60 + 10 * i)});
      tick();
    end
    idle_inputs();
    settle();
    check("arb_count3", 64'(count), 64'(3));
    drive_mem(5'd9, 32'd90);
    drive_alu(5'd10, 32'd100);
    settle();
    check("arb_mem_ready", 64'(mem_ready), 64'(1));
    check("arb_alu_ready", 64'(alu_ready), 64'(0));
    exp_q.push_back({5'd9, 32'd90});
    tick();
    idle_inputs();
    src1 = 5'd9;
    src2 = 5'd10;
    settle();
    check("arb_count4",    64'(count),    64'(4));
    check("arb_full",      64'(full),     64'(1));
    check("arb_fwd1_hit",  64'(fwd1_hit), 64'(exp_fwd));
    check("arb_fwd1_val",  64'(fwd1_val), exp_fwd ? 64'd90 : 64'd0);
    check("arb_fwd2_miss", 64'(fwd2_hit), 64'(0));
    src1 = '0;
    src2 = '0;
    wb_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      expect_write("arb_drain");
      tick();
    end
    settle();
    check("arb_empty", 64'(empty), 64'(1));

    // 6a Register 0: handshaken but never enqueued.
    drive_alu(5'd0, 32'd7);
    src1 = 5'd0;
    settle();
    check("r0_alu_ready", 64'(alu_ready), 64'(1));
    tick();
    idle_inputs();
    settle();
    check("r0_count", 64'(count),    64'(0));
    check("r0_we",    64'(writeEn),  64'(0));
    check("r0_fwd",   64'(fwd1_hit), 64'(0));

    // 6b Reset with three entries queued discards them.
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_alu(5'(11 + i), 32'(110 + i));
      tick();
    end
    idle_inputs();
    settle();
    check("mid_count3", 64'(count), 64'(3));
    rst = 1'b1;
    wb_stall = 1'b0;
    src1 = 5'd11;
    settle();
    check("mid_rst_we",  64'(writeEn),  64'(0));
    check("mid_rst_fwd", 64'(fwd1_hit), 64'(0));
    tick();
    rst = 1'b0;
    settle();
    check("mid_count0", 64'(count), 64'(0));
    for (int i = 0; i < 3; i++) begin
      check("mid_no_we", 64'(writeEn), 64'(0));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
